// File: rtl/lstm_seq_ctrl.sv
// Two-layer LSTM sequencer: walks timesteps, layer-1 cells and layer-2 cells,
// issuing accumulate/write/clear strobes with their memory addresses.
module lstm_seq_ctrl #(
  parameter int TIMESTEP    = 7,
  parameter int LAYR1_INPUT = 53,
  parameter int LAYR1_CELL  = 53,
  parameter int LAYR2_CELL  = 8,
  parameter int AW          = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          hold,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] timestep,
  output logic          acc_x_1,
  output logic          acc_h_1,
  output logic          clr_1,
  output logic          wr_h1,
  output logic          wr_c1,
  output logic [AW-1:0] addr_x1,
  output logic [AW-1:0] rd_addr_w_1,
  output logic [AW-1:0] rd_addr_u_1,
  output logic [AW-1:0] rd_addr_b_1,
  output logic [AW-1:0] rd_addr_h1,
  output logic [AW-1:0] rd_addr_c1,
  output logic [AW-1:0] wr_addr_h1,
  output logic [AW-1:0] wr_addr_c1,
  output logic          acc_x_2,
  output logic          acc_h_2,
  output logic          clr_2,
  output logic          wr_h2,
  output logic          wr_c2,
  output logic [AW-1:0] rd_addr_x2,
  output logic [AW-1:0] rd_addr_w_2,
  output logic [AW-1:0] rd_addr_u_2,
  output logic [AW-1:0] rd_addr_b_2,
  output logic [AW-1:0] rd_addr_h2,
  output logic [AW-1:0] rd_addr_c2,
  output logic [AW-1:0] wr_addr_h2,
  output logic [AW-1:0] wr_addr_c2
);

  localparam logic [AW-1:0] NT  = AW'(TIMESTEP);
  localparam logic [AW-1:0] N1I = AW'(LAYR1_INPUT);
  localparam logic [AW-1:0] N1C = AW'(LAYR1_CELL);
  localparam logic [AW-1:0] N2C = AW'(LAYR2_CELL);
  localparam logic [AW-1:0] ONE = AW'(1);

  typedef enum logic [3:0] {
    IDLE, L1_ACC, L1_DRAIN, L1_WR, L1_CLR,
    L2_ACC, L2_DRAIN, L2_WR, L2_CLR, DONE
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] t, j, m, k;
  logic [AW-1:0] t_n, j_n, m_n, k_n, tm1_n;
  logic          run;

  assign run   = !hold;
  assign tm1_n = t_n - ONE;

  always_comb begin
    state_n = state;
    t_n = t;
    j_n = j;
    m_n = m;
    k_n = k;
    if (run) begin
      case (state)
        IDLE: if (start) begin
          state_n = L1_ACC;
          t_n = '0; j_n = '0; m_n = '0; k_n = '0;
        end
        L1_ACC: begin
          if (k == N1I - ONE) begin state_n = L1_DRAIN; k_n = '0; end
          else k_n = k + ONE;
        end
        L1_DRAIN: state_n = L1_WR;
        L1_WR:    state_n = L1_CLR;
        L1_CLR: begin
          if (j == N1C - ONE) begin state_n = L2_ACC; m_n = '0; end
          else begin state_n = L1_ACC; j_n = j + ONE; end
        end
        L2_ACC: begin
          if (k == N1C - ONE) begin state_n = L2_DRAIN; k_n = '0; end
          else k_n = k + ONE;
        end
        L2_DRAIN: state_n = L2_WR;
        L2_WR:    state_n = L2_CLR;
        L2_CLR: begin
          if (m != N2C - ONE) begin state_n = L2_ACC; m_n = m + ONE; end
          else if (t != NT - ONE) begin state_n = L1_ACC; t_n = t + ONE; j_n = '0; end
          else state_n = DONE;
        end
        DONE: begin
          state_n = IDLE;
          t_n = '0; j_n = '0; m_n = '0; k_n = '0;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Outputs are registered from next-state values so they line up with the
  // state being entered; addresses only move while their state is active.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      t <= '0; j <= '0; m <= '0; k <= '0;
      busy <= 1'b0; done <= 1'b0; timestep <= '0;
      acc_x_1 <= 1'b0; acc_h_1 <= 1'b0; clr_1 <= 1'b0; wr_h1 <= 1'b0; wr_c1 <= 1'b0;
      acc_x_2 <= 1'b0; acc_h_2 <= 1'b0; clr_2 <= 1'b0; wr_h2 <= 1'b0; wr_c2 <= 1'b0;
      addr_x1 <= '0; rd_addr_w_1 <= '0; rd_addr_u_1 <= '0; rd_addr_b_1 <= '0;
      rd_addr_h1 <= '0; rd_addr_c1 <= '0; wr_addr_h1 <= '0; wr_addr_c1 <= '0;
      rd_addr_x2 <= '0; rd_addr_w_2 <= '0; rd_addr_u_2 <= '0; rd_addr_b_2 <= '0;
      rd_addr_h2 <= '0; rd_addr_c2 <= '0; wr_addr_h2 <= '0; wr_addr_c2 <= '0;
    end else begin
      state <= state_n;
      t <= t_n; j <= j_n; m <= m_n; k <= k_n;
      busy     <= (state_n != IDLE);
      done     <= run && (state_n == DONE);
      timestep <= t_n;
      acc_x_1  <= run && (state_n == L1_ACC);
      acc_h_1  <= run && (state_n == L1_ACC) && (t_n != '0);
      clr_1    <= run && (state_n == L1_CLR);
      wr_h1    <= run && (state_n == L1_WR);
      wr_c1    <= run && (state_n == L1_WR);
      acc_x_2  <= run && (state_n == L2_ACC);
      acc_h_2  <= run && (state_n == L2_ACC) && (t_n != '0) && (k_n < N2C);
      clr_2    <= run && (state_n == L2_CLR);
      wr_h2    <= run && (state_n == L2_WR);
      wr_c2    <= run && (state_n == L2_WR);

      if (run && state_n == L1_ACC) begin
        addr_x1     <= t_n * N1I + k_n;
        rd_addr_w_1 <= j_n * N1I + k_n;
        rd_addr_u_1 <= j_n * N1C + k_n;
        rd_addr_b_1 <= j_n;
        rd_addr_h1  <= (t_n != '0) ? tm1_n * N1C + k_n : '0;
      end
      if (run && state_n == L1_WR) begin
        wr_addr_h1 <= t_n * N1C + j_n;
        wr_addr_c1 <= t_n * N1C + j_n;
        rd_addr_c1 <= (t_n != '0) ? tm1_n * N1C + j_n : '0;
      end
      if (run && state_n == L2_ACC) begin
        rd_addr_x2  <= t_n * N1C + k_n;
        rd_addr_w_2 <= m_n * N1C + k_n;
        rd_addr_b_2 <= m_n;
        if (k_n < N2C) rd_addr_u_2 <= m_n * N2C + k_n;
        if (t_n == '0) rd_addr_h2 <= '0;
        else if (k_n < N2C) rd_addr_h2 <= tm1_n * N2C + k_n;
      end
      if (run && state_n == L2_WR) begin
        wr_addr_h2 <= t_n * N2C + m_n;
        wr_addr_c2 <= t_n * N2C + m_n;
        rd_addr_c2 <= (t_n != '0) ? tm1_n * N2C + m_n : '0;
      end
    end
  end

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Bench for lstm_seq_ctrl: a queue of expected output vectors generated from the
// nested timestep/cell/element loops, checked every cycle, plus directed scenarios.
module tb_lstm_seq_ctrl;
  localparam int T = 7, L1I = 53, L1C = 53, L2C = 8, AW = 12;

  typedef struct packed {
    logic busy, done;
    logic [AW-1:0] timestep;
    logic acc_x_1, acc_h_1, clr_1, wr_h1, wr_c1;
    logic [AW-1:0] addr_x1, rd_addr_w_1, rd_addr_u_1, rd_addr_b_1, rd_addr_h1, rd_addr_c1, wr_addr_h1, wr_addr_c1;
    logic acc_x_2, acc_h_2, clr_2, wr_h2, wr_c2;
    logic [AW-1:0] rd_addr_x2, rd_addr_w_2, rd_addr_u_2, rd_addr_b_2, rd_addr_h2, rd_addr_c2, wr_addr_h2, wr_addr_c2;
  } vec_t;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, hold = 1'b0;
  logic busy, done;
  logic [AW-1:0] timestep;
  logic acc_x_1, acc_h_1, clr_1, wr_h1, wr_c1, acc_x_2, acc_h_2, clr_2, wr_h2, wr_c2;
  logic [AW-1:0] addr_x1, rd_addr_w_1, rd_addr_u_1, rd_addr_b_1, rd_addr_h1, rd_addr_c1, wr_addr_h1, wr_addr_c1;
  logic [AW-1:0] rd_addr_x2, rd_addr_w_2, rd_addr_u_2, rd_addr_b_2, rd_addr_h2, rd_addr_c2, wr_addr_h2, wr_addr_c2;

  lstm_seq_ctrl #(.TIMESTEP(T), .LAYR1_INPUT(L1I), .LAYR1_CELL(L1C), .LAYR2_CELL(L2C), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .busy(busy), .done(done), .timestep(timestep),
    .acc_x_1(acc_x_1), .acc_h_1(acc_h_1), .clr_1(clr_1), .wr_h1(wr_h1), .wr_c1(wr_c1),
    .addr_x1(addr_x1), .rd_addr_w_1(rd_addr_w_1), .rd_addr_u_1(rd_addr_u_1), .rd_addr_b_1(rd_addr_b_1),
    .rd_addr_h1(rd_addr_h1), .rd_addr_c1(rd_addr_c1), .wr_addr_h1(wr_addr_h1), .wr_addr_c1(wr_addr_c1),
    .acc_x_2(acc_x_2), .acc_h_2(acc_h_2), .clr_2(clr_2), .wr_h2(wr_h2), .wr_c2(wr_c2),
    .rd_addr_x2(rd_addr_x2), .rd_addr_w_2(rd_addr_w_2), .rd_addr_u_2(rd_addr_u_2), .rd_addr_b_2(rd_addr_b_2),
    .rd_addr_h2(rd_addr_h2), .rd_addr_c2(rd_addr_c2), .wr_addr_h2(wr_addr_h2), .wr_addr_c2(wr_addr_c2));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  vec_t q[$];
  vec_t ev, dv;
  logic mvalid = 1'b0;
  int cyc = 0;

  always_comb begin
    dv = '0;
    dv.busy = busy; dv.done = done; dv.timestep = timestep;
    dv.acc_x_1 = acc_x_1; dv.acc_h_1 = acc_h_1; dv.clr_1 = clr_1; dv.wr_h1 = wr_h1; dv.wr_c1 = wr_c1;
    dv.addr_x1 = addr_x1; dv.rd_addr_w_1 = rd_addr_w_1; dv.rd_addr_u_1 = rd_addr_u_1; dv.rd_addr_b_1 = rd_addr_b_1;
    dv.rd_addr_h1 = rd_addr_h1; dv.rd_addr_c1 = rd_addr_c1; dv.wr_addr_h1 = wr_addr_h1; dv.wr_addr_c1 = wr_addr_c1;
    dv.acc_x_2 = acc_x_2; dv.acc_h_2 = acc_h_2; dv.clr_2 = clr_2; dv.wr_h2 = wr_h2; dv.wr_c2 = wr_c2;
    dv.rd_addr_x2 = rd_addr_x2; dv.rd_addr_w_2 = rd_addr_w_2; dv.rd_addr_u_2 = rd_addr_u_2; dv.rd_addr_b_2 = rd_addr_b_2;
    dv.rd_addr_h2 = rd_addr_h2; dv.rd_addr_c2 = rd_addr_c2; dv.wr_addr_h2 = wr_addr_h2; dv.wr_addr_c2 = wr_addr_c2;
  end

  function automatic logic [AW-1:0] a(input int x);
    return x[AW-1:0];
  endfunction

  function automatic vec_t quiet(input vec_t v);
    vec_t r = v;
    r.done = 0; r.acc_x_1 = 0; r.acc_h_1 = 0; r.clr_1 = 0; r.wr_h1 = 0; r.wr_c1 = 0;
    r.acc_x_2 = 0; r.acc_h_2 = 0; r.clr_2 = 0; r.wr_h2 = 0; r.wr_c2 = 0;
    return r;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // One full run, cycle by cycle, straight from the loop nest; addresses a
  // state does not drive carry over from the previous vector.
  task automatic build_run(input vec_t seed);
    vec_t v = seed;
    for (int t = 0; t < T; t++) begin
      for (int j = 0; j < L1C; j++) begin
        for (int k = 0; k < L1I; k++) begin
          v = quiet(v); v.busy = 1; v.timestep = a(t);
          v.acc_x_1 = 1; v.acc_h_1 = (t > 0);
          v.addr_x1 = a(t*L1I + k); v.rd_addr_w_1 = a(j*L1I + k); v.rd_addr_u_1 = a(j*L1C + k);
          v.rd_addr_h1 = (t > 0) ? a((t-1)*L1C + k) : '0; v.rd_addr_b_1 = a(j);
          q.push_back(v);
        end
        v = quiet(v); q.push_back(v);
        v = quiet(v); v.wr_h1 = 1; v.wr_c1 = 1;
        v.wr_addr_h1 = a(t*L1C + j); v.wr_addr_c1 = a(t*L1C + j);
        v.rd_addr_c1 = (t > 0) ? a((t-1)*L1C + j) : '0;
        q.push_back(v);
        v = quiet(v); v.clr_1 = 1; q.push_back(v);
      end
      for (int m = 0; m < L2C; m++) begin
        for (int k = 0; k < L1C; k++) begin
          v = quiet(v); v.acc_x_2 = 1; v.acc_h_2 = (t > 0 && k < L2C);
          v.rd_addr_x2 = a(t*L1C + k); v.rd_addr_w_2 = a(m*L1C + k); v.rd_addr_b_2 = a(m);
          if (k < L2C) v.rd_addr_u_2 = a(m*L2C + k);
          if (t == 0) v.rd_addr_h2 = '0;
          else if (k < L2C) v.rd_addr_h2 = a((t-1)*L2C + k);
          q.push_back(v);
        end
        v = quiet(v); q.push_back(v);
        v = quiet(v); v.wr_h2 = 1; v.wr_c2 = 1;
        v.wr_addr_h2 = a(t*L2C + m); v.wr_addr_c2 = a(t*L2C + m);
        v.rd_addr_c2 = (t > 0) ? a((t-1)*L2C + m) : '0;
        q.push_back(v);
        v = quiet(v); v.clr_2 = 1; q.push_back(v);
      end
    end
    v = quiet(v); v.done = 1; q.push_back(v);
    v = quiet(v); v.busy = 0; v.timestep = '0; q.push_back(v);
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      q.delete(); ev = '0; mvalid = 1'b1;
    end else if (mvalid) begin
      if (hold) ev = quiet(ev);
      else if (q.size() > 0) ev = q.pop_front();
      else if (start) begin build_run(ev); ev = q.pop_front(); end
      else begin ev = quiet(ev); ev.busy = 0; ev.timestep = '0; end
    end
  end

  int exp_lat = 0, start_cyc = 0, done_cnt = 0, last_done = 0, last_rise = 0;
  logic prev_busy = 1'b0;

  always @(negedge clk) begin
    if (mvalid) begin
      checks++;
      if (dv !== ev) begin
        errors++;
        if (errors < 20) $display("FAIL vec cyc=%0d got=%h expected=%h", cyc, dv, ev);
      end
      if (busy && !prev_busy) begin start_cyc = cyc; last_rise = cyc; end
      if (done) begin
        done_cnt++; last_done = cyc;
        chk("latency", cyc - start_cyc, exp_lat);
      end
      prev_busy = busy;
    end
  end

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin @(negedge clk); n++; end
    if (done !== 1'b1) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int cnt;
    logic [AW-1:0] snap;
    // Pin the model with hand-derived values before the DUT runs.
    build_run('0);
    chk("run_len", q.size(), 23914);
    chk("done_slot", int'(q[23912].done), 1);
    cnt = 0; for (int i = 0; i < 53; i++) cnt += int'(q[i].acc_h_1);
    chk("t0j0_acc_h1", cnt, 0);
    chk("t0j0_wr", int'(q[54].wr_h1), 1);
    chk("t0j0_wr_addr", int'(q[54].wr_addr_h1), 0);
    chk("t1j2_x_lo", int'(q[3528].addr_x1), 53);
    chk("t1j2_x_hi", int'(q[3580].addr_x1), 105);
    chk("t1j2_h_lo", int'(q[3528].rd_addr_h1), 0);
    chk("t1j2_h_hi", int'(q[3580].rd_addr_h1), 52);
    chk("t1j2_wr_addr", int'(q[3582].wr_addr_h1), 55);
    cnt = 0; for (int i = 9968; i < 9968 + 53; i++) cnt += int'(q[i].acc_h_2);
    chk("t2m3_acc_h2", cnt, 8);
    chk("t2m3_h_lo", int'(q[9968].rd_addr_h2), 8);
    chk("t2m3_h_hi", int'(q[9975].rd_addr_h2), 15);
    chk("t2m3_wr", int'(q[10022].wr_h2), 1);
    chk("t2m3_wr_addr", int'(q[10022].wr_addr_h2), 19);
    q.delete();

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", int'(busy), 0);

    // Single start pulse at defaults.
    exp_lat = 23912;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", int'(busy), 1);
    wait_done(30000);
    @(negedge clk);
    chk("busy_after_done", int'(busy), 0);
    chk("done_once", done_cnt, 1);

    // Reset during L2_WR, then replay from t=0.
    start = 1'b1; @(negedge clk); start = 1'b0;
    cnt = 0;
    while (wr_h2 !== 1'b1 && cnt < 5000) begin @(negedge clk); cnt++; end
    chk("saw_l2_wr", int'(wr_h2), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_all_zero", int'(dv == '0), 1);
    rst = 1'b0;
    start = 1'b1; @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("replay_t0", int'(timestep), 0);
    repeat (100) @(negedge clk);
    rst = 1'b1; @(negedge clk); rst = 1'b0;

    // Start held high throughout, with a 5-cycle hold mid-L1_ACC.
    exp_lat = 23917;
    start = 1'b1;
    repeat (20) @(negedge clk);
    snap = addr_x1;
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_acc_off", int'(acc_x_1), 0);
      chk("hold_addr_frozen", int'(addr_x1), int'(snap));
    end
    hold = 1'b0;
    wait_done(30000);
    @(negedge clk);
    chk("held_start_idle", int'(busy), 0);
    @(negedge clk);
    chk("held_start_rerun", int'(busy), 1);
    repeat (3) @(negedge clk);
    chk("restart_gap", last_rise - last_done, 2);
    repeat (50) @(negedge clk);
    start = 1'b0;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("done_pulses", done_cnt, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
